inst_mem_write_router: RTL

Parametrised successor to the MCU-top instruction-memory write demux. The existing demux splits host writes between MCU instruction RAM and the flash-loader buffer on the address MSB, with one register stage. This block generalises that split to NUM_TARGETS destinations selected by the top address bits, adds byte enables and a buffering FIFO, and adds valid/ready backpressure per target plus write-protect masking with drop accounting. It sits between the host/debug loader write port and the instruction-memory and flash-buffer write ports.

---
 rtl/inst_mem_router_pkg.sv | 22 ++
 rtl/inst_mem_write_router_fifo.sv | 60 ++++++
 rtl/inst_mem_write_router.sv | 129 ++++++++++++
 3 files changed

// File: rtl/inst_mem_router_pkg.sv
// Shared types for the instruction-memory write router: output FSM states,
// the default write-entry layout and drop-counter width.
package inst_mem_router_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } out_state_t;

    localparam int ENTRY_ADDR_BITS  = 14;
    localparam int ENTRY_DATA_WIDTH = 32;
    localparam int ENTRY_BE_BITS    = ENTRY_DATA_WIDTH / 8;

    typedef struct packed {
        logic [ENTRY_ADDR_BITS-1:0]  addr;
        logic [ENTRY_DATA_WIDTH-1:0] data;
        logic [ENTRY_BE_BITS-1:0]    be;
    } wr_entry_t;

    localparam int DROP_COUNT_BITS = 8;

endpackage

// File: rtl/inst_mem_write_router_fifo.sv
// Show-ahead synchronous FIFO with occupancy level, registered ready and
// synchronous flush. DEPTH must be a power of two so pointers wrap naturally.
module sync_fifo_fl #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_level,
    output logic                       o_empty,
    output logic                       o_ready
);

    localparam int PTR_BITS   = $clog2(DEPTH);
    localparam int LEVEL_BITS = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [PTR_BITS-1:0]   r_wr_ptr;
    logic [PTR_BITS-1:0]   r_rd_ptr;
    logic [LEVEL_BITS-1:0] r_level;
    logic                  r_ready;

    logic                  w_push;
    logic                  w_pop;
    logic [LEVEL_BITS-1:0] w_level_nxt;

    // Admission uses the registered ready only, so a same-cycle pop never frees a full slot.
    assign w_push      = i_push && r_ready;
    assign w_pop       = i_pop && (r_level != '0);
    assign w_level_nxt = r_level + LEVEL_BITS'(w_push) - LEVEL_BITS'(w_pop);

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ready  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
            r_level <= w_level_nxt;
            r_ready <= (w_level_nxt < LEVEL_BITS'(DEPTH));
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_reset && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_level = r_level;
    assign o_empty = (r_level == '0);
    assign o_ready = r_ready;

endmodule

// File: rtl/inst_mem_write_router.sv
// Routes host instruction-memory writes to NUM_TARGETS destinations chosen by the
// top address bits, through an input FIFO, with per-target backpressure and drop accounting.
module inst_mem_write_router
    import inst_mem_router_pkg::*;
#(
    parameter int NUM_TARGETS = 2,
    parameter int ADDR_BITS   = 14,
    parameter int DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int SEL_BITS    = $clog2(NUM_TARGETS)
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic                              i_wr_valid,
    output logic                              o_wr_ready,
    input  logic [ADDR_BITS-1:0]              i_wr_addr,
    input  logic [DATA_WIDTH-1:0]             i_wr_data,
    input  logic [DATA_WIDTH/8-1:0]           i_wr_be,
    input  logic [NUM_TARGETS-1:0]            i_target_enable,
    input  logic                              i_flush,
    input  logic                              i_drop_clear,
    output logic [NUM_TARGETS-1:0]            o_tgt_we,
    input  logic [NUM_TARGETS-1:0]            i_tgt_ready,
    output logic [ADDR_BITS-SEL_BITS-1:0]     o_tgt_addr,
    output logic [DATA_WIDTH-1:0]             o_tgt_data,
    output logic [DATA_WIDTH/8-1:0]           o_tgt_be,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_fifo_level,
    output logic                              o_drop_flag,
    output logic [DROP_COUNT_BITS-1:0]        o_drop_count,
    output logic                              o_busy
);

    localparam int BE_BITS    = DATA_WIDTH / 8;
    localparam int LOCAL_BITS = ADDR_BITS - SEL_BITS;

    typedef struct packed {
        logic [ADDR_BITS-1:0]  addr;
        logic [DATA_WIDTH-1:0] data;
        logic [BE_BITS-1:0]    be;
    } entry_t;

    entry_t                w_in_entry;
    entry_t                w_head;
    logic                  w_empty;
    logic [SEL_BITS-1:0]   w_head_sel;
    logic                  w_done;
    logic                  w_pop;
    logic                  w_dispatch;
    logic                  w_drop;

    out_state_t            r_state;
    logic [SEL_BITS-1:0]   r_sel;

    assign w_in_entry = '{addr: i_wr_addr, data: i_wr_data, be: i_wr_be};

    sync_fifo_fl #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (i_flush),
        .i_push  (i_wr_valid),
        .i_pop   (w_pop),
        .i_data  (w_in_entry),
        .o_data  (w_head),
        .o_level (o_fifo_level),
        .o_empty (w_empty),
        .o_ready (o_wr_ready)
    );

    assign w_head_sel = w_head.addr[ADDR_BITS-1 -: SEL_BITS];
    assign w_done     = (r_state == HOLD) && i_tgt_ready[r_sel];
    // A completing HOLD pops the next head in the same cycle for back-to-back issue.
    assign w_pop      = !i_flush && !w_empty && ((r_state == IDLE) || w_done);
    assign w_dispatch = w_pop && i_target_enable[w_head_sel];
    assign w_drop     = w_pop && !i_target_enable[w_head_sel];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            o_tgt_we   <= '0;
            o_tgt_addr <= '0;
            o_tgt_data <= '0;
            o_tgt_be   <= '0;
        end else if (i_flush) begin
            r_state  <= IDLE;
            o_tgt_we <= '0;
        end else begin
            case (r_state)
                IDLE, HOLD: begin
                    if (w_dispatch) begin
                        r_state    <= HOLD;
                        r_sel      <= w_head_sel;
                        o_tgt_we   <= NUM_TARGETS'(1) << w_head_sel;
                        o_tgt_addr <= w_head.addr[LOCAL_BITS-1:0];
                        o_tgt_data <= w_head.data;
                        o_tgt_be   <= w_head.be;
                    end else if ((r_state == IDLE) || w_done) begin
                        r_state  <= IDLE;
                        o_tgt_we <= '0;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    o_tgt_we <= '0;
                end
            endcase
        end
    end

    // A drop coinciding with drop_clear leaves exactly that one drop recorded.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_drop_flag  <= 1'b0;
            o_drop_count <= '0;
        end else if (i_drop_clear) begin
            o_drop_flag  <= w_drop;
            o_drop_count <= w_drop ? DROP_COUNT_BITS'(1) : '0;
        end else if (w_drop) begin
            o_drop_flag <= 1'b1;
            if (o_drop_count != '1) o_drop_count <= o_drop_count + DROP_COUNT_BITS'(1);
        end
    end

    assign o_busy = !w_empty || (r_state == HOLD);

endmodule
